// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch sequencer.
//   fetch_state_t   - sequencer FSM states
//   BYTES_PER_INSTR - bytes per instruction word
//   lane_onehot()   - big-endian IR byte-lane strobe for a byte index
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int unsigned BYTES_PER_INSTR = 4;

    // Byte 0 (at pc) is the opcode byte and lands in the most significant lane.
    function automatic logic [3:0] lane_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: per-byte wait counter for the fetch sequencer.
//   clk_i, rst_i  - clock and asynchronous active-high reset
//   clear_i       - restart the count (outside REQ, or on a memory ack)
//   run_i         - count this cycle (sequencer is waiting in REQ)
//   expired_o     - this is the last allowed waiting cycle
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 on the first waiting cycle, so TIMEOUT_CYCLES-1 marks the last one.
    assign expired_o = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches one 32-bit instruction as four bytes from byte-wide memory.
//   clk_i, rst_i  - clock and asynchronous active-high reset
//   fetch_go_i    - start a fetch at pc (IDLE only)
//   pc_load_i     - load pc from pc_next_i (IDLE only, wins over fetch_go_i)
//   pc_next_i     - branch/jump target
//   mem_ack_i     - memory byte valid this cycle
//   mem_req_o     - byte read request
//   mem_addr_o    - byte address pc + byte index (wraps)
//   rw_o          - 0 while reading, 1 otherwise
//   ir_write_o    - one-hot IR byte-lane strobe (Mealy on mem_ack_i)
//   pc_o          - current instruction address
//   busy_o        - not IDLE
//   fetch_done_o  - one-cycle pulse when the IR holds a complete instruction
//   fetch_err_o   - sticky timeout flag, cleared by the next fetch
// Build option: define FETCH_TIMEOUT_EN to abort a byte wait after TIMEOUT_CYCLES cycles;
// without it REQ waits indefinitely and fetch_err_o is tied low.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned PC_RESET       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_go_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              rw_o,
    output logic [3:0]        ir_write_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              fetch_done_o,
    output logic              fetch_err_o
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        idx_q, idx_d;
    logic              timeout;

`ifdef FETCH_TIMEOUT_EN
    logic err_q, err_d;

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  ((state_q != REQ) || mem_ack_i),
        .run_i    (state_q == REQ),
        .expired_o(timeout)
    );

    assign fetch_err_o = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign fetch_err_o        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
`ifdef FETCH_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pc_load_i) begin
                    pc_d = pc_next_i;
                end else if (fetch_go_i) begin
                    idx_d   = '0;
`ifdef FETCH_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    if (idx_q == 2'(BYTES_PER_INSTR - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (timeout) begin
                    // Abandon the fetch; pc stays on the faulting instruction.
`ifdef FETCH_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            DONE: begin
                pc_d    = pc_q + ADDR_W'(BYTES_PER_INSTR);
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(PC_RESET);
            idx_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req_o    = (state_q == REQ);
    assign rw_o         = (state_q != REQ);
    assign mem_addr_o   = pc_q + ADDR_W'(idx_q);
    assign ir_write_o   = (state_q == REQ && mem_ack_i) ? lane_onehot(idx_q) : 4'b0000;
    assign pc_o         = pc_q;
    assign busy_o       = (state_q != IDLE);
    assign fetch_done_o = (state_q == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized self-checking bench for fetch_sequencer.
// Reference model: a pc variable plus the rule "byte i of a fetch is read from pc+i and
// strobes lane 8>>i"; every cycle is predicted from that and the stimulus the bench chose.
module tb_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_go_i, pc_load_i, mem_ack_i;
    logic [15:0] pc_next_i;
    logic        mem_req_o, rw_o, busy_o, fetch_done_o, fetch_err_o;
    logic [15:0] mem_addr_o, pc_o;
    logic [3:0]  ir_write_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] pc_model;

    always #5 clk_i = ~clk_i;

    fetch_sequencer #(
        .ADDR_W        (16),
        .PC_RESET      (0),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_go_i  (fetch_go_i),
        .pc_load_i   (pc_load_i),
        .pc_next_i   (pc_next_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .rw_o        (rw_o),
        .ir_write_o  (ir_write_o),
        .pc_o        (pc_o),
        .busy_o      (busy_o),
        .fetch_done_o(fetch_done_o),
        .fetch_err_o (fetch_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive inputs mid-low-phase, then sample 1ns later, well clear of the rising edge.
    task automatic step(input logic go, input logic load, input logic [15:0] nxt, input logic ack);
        @(negedge clk_i);
        fetch_go_i = go;
        pc_load_i  = load;
        pc_next_i  = nxt;
        mem_ack_i  = ack;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".busy"}, {31'd0, busy_o}, 0);
        check_eq({tag, ".req"}, {31'd0, mem_req_o}, 0);
        check_eq({tag, ".rw"}, {31'd0, rw_o}, 1);
        check_eq({tag, ".irw"}, {28'd0, ir_write_o}, 0);
        check_eq({tag, ".done"}, {31'd0, fetch_done_o}, 0);
        check_eq({tag, ".pc"}, {16'd0, pc_o}, {16'd0, pc_model});
    endtask

    // One full fetch; up to wait_max stall cycles per byte; optional ignored noise inputs.
    task automatic do_fetch(input string tag, input int wait_max, input bit stray);
        logic [15:0] pc0;
        int          w;
        pc0 = pc_model;
        step(1'b1, 1'b0, 16'($urandom), 1'b0);
        check_idle({tag, ".go"});
        for (int i = 0; i < 4; i++) begin
            w = (wait_max == 0) ? 0 : int'($urandom_range(0, wait_max));
            for (int k = 0; k <= w; k++) begin
                step(stray ? 1'($urandom) : 1'b0, stray ? 1'($urandom) : 1'b0,
                     16'($urandom), (k == w) ? 1'b1 : 1'b0);
                check_eq({tag, ".req"}, {31'd0, mem_req_o}, 1);
                check_eq({tag, ".rw"}, {31'd0, rw_o}, 0);
                check_eq({tag, ".addr"}, {16'd0, mem_addr_o}, 32'(16'(pc0 + 16'(i))));
                check_eq({tag, ".irw"}, {28'd0, ir_write_o},
                         (k == w) ? 32'(4'b1000 >> i) : 32'd0);
                check_eq({tag, ".pc"}, {16'd0, pc_o}, {16'd0, pc0});
                check_eq({tag, ".done"}, {31'd0, fetch_done_o}, 0);
                check_eq({tag, ".err"}, {31'd0, fetch_err_o}, 0);
            end
        end
        // Done cycle; a stray ack here must not strobe the IR.
        step(stray ? 1'($urandom) : 1'b0, stray ? 1'($urandom) : 1'b0,
             16'($urandom), stray ? 1'b1 : 1'b0);
        check_eq({tag, ".done"}, {31'd0, fetch_done_o}, 1);
        check_eq({tag, ".dbusy"}, {31'd0, busy_o}, 1);
        check_eq({tag, ".dreq"}, {31'd0, mem_req_o}, 0);
        check_eq({tag, ".dirw"}, {28'd0, ir_write_o}, 0);
        pc_model = pc0 + 16'd4;
        step(1'b0, 1'b0, 16'd0, 1'b0);
        check_idle({tag, ".end"});
    endtask

    initial begin
        fetch_go_i = 0; pc_load_i = 0; pc_next_i = '0; mem_ack_i = 0;
        rst_i = 1'b1;
        pc_model = 16'd0;
        #12;
        check_idle("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Zero-wait fetch from reset, then stalled bytes (3 waits each, 16 REQ cycles).
        do_fetch("zero_wait", 0, 1'b0);
        check_eq("pc_after_first", {16'd0, pc_o}, 32'd4);
        pc_model = pc_o;
        begin
            logic [15:0] pc0;
            int          cyc;
            pc0 = pc_model;
            cyc = 0;
            step(1'b1, 1'b0, 16'd0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    step(1'b0, 1'b0, 16'd0, (k == 3) ? 1'b1 : 1'b0);
                    cyc++;
                    check_eq("slow.irw", {28'd0, ir_write_o},
                             (k == 3) ? 32'(4'b1000 >> i) : 32'd0);
                    check_eq("slow.addr", {16'd0, mem_addr_o}, 32'(16'(pc0 + 16'(i))));
                end
            end
            step(1'b0, 1'b0, 16'd0, 1'b0);
            check_eq("slow.done", {31'd0, fetch_done_o}, 1);
            check_eq("slow.cycles", cyc, 16);
            pc_model = pc0 + 16'd4;
            step(1'b0, 1'b0, 16'd0, 1'b0);
            check_idle("slow.end");
        end

        // pc_load beats fetch_go; then fetch across the address wrap.
        step(1'b1, 1'b1, 16'hFFFE, 1'b0);
        step(1'b0, 1'b0, 16'h1234, 1'b1);
        pc_model = 16'hFFFE;
        check_idle("load_prio");
        do_fetch("wrap", 0, 1'b0);
        check_eq("pc_after_wrap", {16'd0, pc_o}, 32'h0002);

        // Random pc targets, random stalls and ignored noise inputs.
        for (int t = 0; t < 20; t++) begin
            logic [15:0] tgt;
            tgt = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 1'b1, tgt, 1'b1);
                pc_model = tgt;
            end
            do_fetch("rand", 4, 1'b1);
        end

        // Reset mid-fetch after the second byte.
        step(1'b1, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        @(negedge clk_i);
        mem_ack_i = 1'b1;
        rst_i = 1'b1;
        #1;
        pc_model = 16'd0;
        check_idle("mid_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 16'd0, 1'b1);
            check_idle("post_rst");
        end

`ifdef FETCH_TIMEOUT_EN
        step(1'b0, 1'b1, 16'h0100, 1'b0);
        pc_model = 16'h0100;
        step(1'b1, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
            check_eq("to.req", {31'd0, mem_req_o}, 1);
        end
        step(1'b0, 1'b0, 16'd0, 1'b0);
        check_idle("to.abort");
        check_eq("to.err", {31'd0, fetch_err_o}, 1);
        do_fetch("to.clear", 2, 1'b0);
`else
        // No timeout: a 40-cycle stall keeps waiting and never flags an error.
        step(1'b1, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
        end
        check_eq("nt.busy", {31'd0, busy_o}, 1);
        check_eq("nt.req", {31'd0, mem_req_o}, 1);
        check_eq("nt.err", {31'd0, fetch_err_o}, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b1);
            check_eq("nt.irw", {28'd0, ir_write_o}, 32'(4'b1000 >> i));
        end
        step(1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("nt.done", {31'd0, fetch_done_o}, 1);
        pc_model = pc_model + 16'd4;
        step(1'b0, 1'b0, 16'd0, 1'b0);
        check_idle("nt.end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
